// File: rtl/multi_sel_chk.sv
// multi_sel_chk: frames the x1/x3/x7/x8 product stream, recovers the operand and flags bad samples (err_cnt under MULTI_CHK_ERRCNT_EN).
module multi_sel_chk #(
  parameter int W_D = 8,
  parameter int W_O = W_D + 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           input_grant,
  input  logic [W_O-1:0] out,
  output logic [W_D-1:0] d_out,
  output logic           d_valid,
  output logic           err,
  output logic [1:0]     err_phase,
  output logic           locked
`ifdef MULTI_CHK_ERRCNT_EN
  , output logic [7:0]   err_cnt
`endif
);
  typedef enum logic [2:0] {HUNT, P1, P2, P3, P0} state_t;
  state_t state, state_n;
  logic [W_D-1:0] d_r, d_n;
  logic bad, bad_n, err_n, valid_n, mid, mis;
  logic [1:0] phase, phase_n;
  logic [W_O-1:0] dx, expv;
  always_comb begin
    dx = W_O'(d_r);
    expv = state == P1 ? (dx << 1) + dx : state == P2 ? (dx << 3) - dx : dx << 3;
    mid = state == P1 || state == P2 || state == P3;
    phase = state == P1 ? 2'd1 : state == P2 ? 2'd2 : state == P3 ? 2'd3 : 2'd0;
    mis = out != expv;
    state_n = state;
    d_n = d_r;
    bad_n = bad;
    err_n = 1'b0;
    valid_n = 1'b0;
    if (input_grant) begin
      // Any grant is a phase-0 capture; mid-block it is also a resync error.
      d_n = out[W_D-1:0];
      bad_n = |out[W_O-1:W_D];
      err_n = mid || bad_n;
      state_n = P1;
    end else if (state == P0) begin
      err_n = 1'b1;
      state_n = HUNT;
    end else if (mid) begin
      err_n = mis;
      bad_n = bad | mis;
      valid_n = state == P3 && !bad && !mis;
      state_n = state == P1 ? P2 : state == P2 ? P3 : P0;
    end
    phase_n = err_n ? phase : err_phase;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      d_r <= '0;
      bad <= 1'b0;
      d_out <= '0;
      d_valid <= 1'b0;
      err <= 1'b0;
      err_phase <= 2'd0;
      locked <= 1'b0;
    end else begin
      state <= state_n;
      d_r <= d_n;
      bad <= bad_n;
      d_out <= valid_n ? d_r : d_out;
      d_valid <= valid_n;
      err <= err_n;
      err_phase <= phase_n;
      locked <= state_n != HUNT;
    end
  end
`ifdef MULTI_CHK_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= 8'd0;
    else if (err_n && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif
endmodule

// File: doc/multi_sel_chk.md
# multi_sel_chk

Receive-side checker for the shift-multiply product stream. It consumes the 4-cycle product sequence (x1, x3, x7, x8 of an 8-bit operand), framed by the `input_grant` strobe. It recovers the operand, verifies every product against the recovered operand, and reports a validated operand or an error per block. It sits downstream of the multiplier-sequencer, on the same clock.

## Interface
Parameters:
- `W_D`, default 8: operand width.
- `W_O`, default `W_D`+3: product width; must be at least `W_D`+3.

Ports:
- `clk`, input, 1: clock. All logic is rising-edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `input_grant`, input, 1: frame strobe. High on the x1 sample only.
- `out`, input, `W_O`: product stream sample.
- `d_out`, output reg, `W_D`: recovered operand of the last validated block.
- `d_valid`, output reg, 1: one-cycle pulse; `d_out` is valid and checked.
- `err`, output reg, 1: one-cycle pulse; a protocol or arithmetic error occurred.
- `err_phase`, output reg, 2: phase (0–3) of the offending sample. Held until the next error.
- `locked`, output reg, 1: high while framing is acquired.
- `err_cnt`, output reg, 8: saturating error count. Present only with `MULTI_CHK_ERRCNT_EN`.

## Operation
States: `HUNT`, `P1`, `P2`, `P3`, `P0`. Reset enters `HUNT`.

Phase-0 capture (applies in `HUNT`, `P0`, and on resync):
- `d_r` <= `out[W_D-1:0]`; `bad` <= 0.
- If `out[W_O-1:W_D]` != 0: error, phase 0, `bad` <= 1.

Transitions:
- `HUNT`: wait for `input_grant`=1, then do phase-0 capture and go to `P1`. Samples with `input_grant`=0 are ignored, with no error.
- `P1`: expects `input_grant`=0 and `out` == 3·`d_r`. Go to `P2`.
- `P2`: expects `out` == 7·`d_r`. Go to `P3`.
- `P3`: expects `out` == 8·`d_r`. Go to `P0`.
  - If the block is clean (`bad`=0 and this sample matches), pulse `d_valid` and load `d_out` <= `d_r`.
- `P0`: expects `input_grant`=1.
  - If `input_grant`=1: phase-0 capture, go to `P1`.
  - If `input_grant`=0: error, phase 0, go to `HUNT`.

Errors in `P1`–`P3`:
- Value mismatch with `input_grant`=0: error at that phase, `bad` <= 1. The sequence advances normally, and `d_valid` is suppressed for that block.
- `input_grant`=1 (early grant): error at the current phase. Treat the sample as phase-0 capture and go to `P1` (resync). `locked` stays 1.

Arithmetic (all in `W_O` bits; no overflow because 8·(2^`W_D`−1) < 2^`W_O`):
- 3d = (d<<1)+d
- 7d = (d<<3)−d
- 8d = d<<3

Status outputs:
- `locked` = 1 in `P1`/`P2`/`P3`/`P0`; 0 in `HUNT`. Registered.
- At most one error per sample; `err_phase` takes that sample's phase.

## Timing
- Inputs are sampled on every rising edge.
- `err`, `err_phase`, `d_valid`, `d_out`, `locked` update on the edge that samples the causing input, so they are visible one cycle after the sample is presented.
- Latency: `d_valid` is seen one cycle after the x8 sample is presented, i.e. 4 cycles after the grant sample is presented.
- Throughput: one block per 4 cycles, back-to-back. `P0` is the grant sample of the next block; there is no idle cycle.
- Reset values: `d_out`=0, `d_valid`=0, `err`=0, `err_phase`=0, `locked`=0, `err_cnt`=0, state `HUNT`.
- Reset mid-block drops the block with no `d_valid` and no `err`.
- Reset takes priority over all other events in the same cycle.

## Configuration
- Macro: `MULTI_CHK_ERRCNT_EN`.
- Defined:
  - `err_cnt` port and register exist.
  - `err_cnt` increments on every `err` pulse and saturates at 255.
  - Cleared only by `rst`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Clean block, d=0x05: grant=1 with stream 5, then 15, 35, 40 → `d_valid`=1 and `d_out`=0x05 one cycle after the 40 sample; `err`=0; `locked`=1.
- Back-to-back blocks 0xFF then 0x00 (255, 765, 1785, 2040, 0, 0, 0, 0) → two `d_valid` pulses 4 cycles apart, `d_out` 0xFF then 0x00, no error.
- Corrupt x7, d=0x05: stream 5, 15, 36, 40 → `err`=1 with `err_phase`=2, no `d_valid`; the following clean block 0x03 (3, 9, 21, 24) is validated.
- Early grant: grant=1 on the x7 slot with value 0x10, then 48, 112, 128 → `err` with `err_phase`=2; the block resyncs and `d_valid` fires with `d_out`=0x10.
- Missing grant: after a clean block, `input_grant`=0 on the next slot → `err` with `err_phase`=0 and `locked`=0. The next grant re-locks; phase-0 upper bits nonzero (0x105) → `err` with `err_phase`=0 and no `d_valid`.
- `rst`=1 after the x3 sample of a block → all outputs 0 next cycle, no `d_valid`. With `MULTI_CHK_ERRCNT_EN`, 300 forced errors give `err_cnt`=255.
